// File: rtl/pwm_duty_calc_if.sv
// Handshake/result bundle between the PWM phase detector, the duty calculator
// and the register slice that consumes its results.
interface pwm_duty_calc_if #(
  parameter int CNT_W  = 32,
  parameter int FRAC_W = 10
);
  logic [CNT_W-1:0] count_high_pwm;
  logic [CNT_W-1:0] count_low_pwm;
  logic             hready_intr;
  logic             lready_intr;
  logic             err_clr;
  logic [FRAC_W:0]  duty;
  logic [CNT_W:0]   period;
  logic             duty_valid;
  logic             busy;
  logic             overrun;
  logic             div_zero;

  modport master (
    output count_high_pwm, count_low_pwm, hready_intr, lready_intr, err_clr,
    input  duty, period, duty_valid, busy, overrun, div_zero
  );

  modport slave (
    input  count_high_pwm, count_low_pwm, hready_intr, lready_intr, err_clr,
    output duty, period, duty_valid, busy, overrun, div_zero
  );
endinterface

// File: rtl/pwm_duty_calc.sv
// Pairs high/low phase counts and computes duty = floor(high * 2^FRAC_W / (high + low))
// with a bit-serial restoring divider; results are strobed by duty_valid.
module pwm_duty_calc #(
  parameter int CNT_W  = 32,
  parameter int FRAC_W = 10
) (
  input logic              clk,
  input logic              reset,
  pwm_duty_calc_if.slave   bus
);

  localparam int CW = $clog2(FRAC_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  high_held_q, high_held_d;
  logic              high_vld_q, high_vld_d;
  logic [CNT_W:0]    sum_q, sum_d;
  logic [CNT_W+1:0]  rem_q, rem_d;
  logic [FRAC_W:0]   quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FRAC_W:0]   duty_q, duty_d;
  logic [CNT_W:0]    period_q, period_d;
  logic              duty_valid_q, duty_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              div_zero_q, div_zero_d;

  logic              pair_done;
  logic [CNT_W:0]    pair_sum;
  logic              rem_ge;
  logic [CNT_W+1:0]  rem_sub;
  logic              overrun_set;
  logic              div_zero_set;

  // A low count only forms a pair when a high count is already waiting.
  assign pair_done = bus.lready_intr & high_vld_q;
  assign pair_sum  = {1'b0, high_held_q} + {1'b0, bus.count_low_pwm};
  assign rem_ge    = rem_q >= {1'b0, sum_q};
  assign rem_sub   = rem_q - {1'b0, sum_q};

  always_comb begin
    high_vld_d  = high_vld_q;
    high_held_d = high_held_q;
    if (pair_done) begin
      high_vld_d = 1'b0;
    end
    // Capture after pairing so a simultaneous high is kept for the next pair.
    if (bus.hready_intr) begin
      high_held_d = bus.count_high_pwm;
      high_vld_d  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    duty_d       = duty_q;
    period_d     = period_q;
    duty_valid_d = 1'b0;
    busy_d       = busy_q;
    div_zero_set = 1'b0;
    overrun_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pair_done) begin
          sum_d  = pair_sum;
          rem_d  = {2'b00, high_held_q};
          quo_d  = '0;
          cnt_d  = CW'(FRAC_W);
          busy_d = 1'b1;
          if (pair_sum == '0) begin
            state_d      = DONE;
            div_zero_set = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        overrun_set = pair_done;
        if (rem_ge) begin
          quo_d[cnt_q] = 1'b1;
          rem_d        = rem_sub << 1;
        end else begin
          rem_d = rem_q << 1;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        overrun_set  = pair_done;
        duty_d       = quo_q;
        period_d     = sum_q;
        duty_valid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky flags: a new event in the same cycle wins over the clear.
  always_comb begin
    overrun_d  = overrun_q;
    div_zero_d = div_zero_q;
    if (bus.err_clr) begin
      overrun_d  = 1'b0;
      div_zero_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (div_zero_set) begin
      div_zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      high_held_q  <= '0;
      high_vld_q   <= 1'b0;
      sum_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      duty_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      high_held_q  <= high_held_d;
      high_vld_q   <= high_vld_d;
      sum_q        <= sum_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      duty_valid_q <= duty_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      div_zero_q   <= div_zero_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.period     = period_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.div_zero   = div_zero_q;

endmodule

// File: tb/tb_pwm_duty_calc.sv
// Directed plus randomized bench for pwm_duty_calc against an arithmetic duty model.
module tb_pwm_duty_calc;

  localparam int CNT_W  = 32;
  localparam int FRAC_W = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pwm_duty_calc_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) bus ();

  pwm_duty_calc #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #2 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_h(input logic [31:0] v);
    bus.count_high_pwm = v;
    bus.hready_intr    = 1'b1;
    tick();
    bus.hready_intr    = 1'b0;
  endtask

  task automatic pulse_l(input logic [31:0] v);
    bus.count_low_pwm = v;
    bus.lready_intr   = 1'b1;
    tick();
    bus.lready_intr   = 1'b0;
  endtask

  task automatic pulse_both(input logic [31:0] hv, input logic [31:0] lv);
    bus.count_high_pwm = hv;
    bus.count_low_pwm  = lv;
    bus.hready_intr    = 1'b1;
    bus.lready_intr    = 1'b1;
    tick();
    bus.hready_intr    = 1'b0;
    bus.lready_intr    = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    int v;
    v = 0;
    repeat (n) begin
      tick();
      if (bus.duty_valid) v++;
    end
    chk(tag, v, 0);
  endtask

  // Called k0 edges after the lready edge that completed the pair (h, l).
  task automatic wait_result(input logic [31:0] h, input logic [31:0] l, input int k0);
    logic [63:0] s, ed;
    int lat, exp_lat, busy_cnt;
    bit seen;
    s       = {32'b0, h} + {32'b0, l};
    ed      = (s == 0) ? 64'd0 : ({32'b0, h} << FRAC_W) / s;
    exp_lat = (s == 0) ? 1 : FRAC_W + 2;
    busy_cnt = bus.busy ? 1 : 0;
    seen = 1'b0;
    lat  = k0;
    while (!seen && lat < k0 + 40) begin
      tick();
      lat++;
      if (bus.duty_valid) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    chk("result_seen", seen, 1);
    if (seen) begin
      chk("latency", lat, exp_lat);
      chk("duty", bus.duty, ed);
      chk("period", bus.period, s);
      chk("busy_at_valid", bus.busy, 0);
      if (k0 == 0) chk("busy_cycles", busy_cnt, exp_lat);
      tick();
      chk("valid_one_cycle", bus.duty_valid, 0);
      chk("duty_hold", bus.duty, ed);
    end
  endtask

  initial begin
    logic [31:0] rh, rl;
    bus.count_high_pwm = '0;
    bus.count_low_pwm  = '0;
    bus.hready_intr    = 1'b0;
    bus.lready_intr    = 1'b0;
    bus.err_clr        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", bus.duty, 0);
    chk("rst_period", bus.period, 0);
    chk("rst_valid", bus.duty_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_div_zero", bus.div_zero, 0);
    reset = 1'b1;
    tick();

    // Nominal and extremes
    pulse_h(23437); pulse_l(7812); wait_result(23437, 7812, 0);
    pulse_h(1);     pulse_l(0);    wait_result(1, 0, 0);
    pulse_h(0);     pulse_l(5);    wait_result(0, 5, 0);
    pulse_h(1);     pulse_l(2);    wait_result(1, 2, 0);
    chk("nominal_duty_const", bus.duty, 341);

    // Zero divisor
    pulse_h(0); pulse_l(0); wait_result(0, 0, 0);
    chk("div_zero_set", bus.div_zero, 1);
    pulse_clr();
    chk("div_zero_clr", bus.div_zero, 0);
    chk("overrun_clean", bus.overrun, 0);

    // Orphan lready, then overwritten high
    pulse_l(50);
    quiet(16, "orphan_lready");
    chk("orphan_busy", bus.busy, 0);
    pulse_h(100); pulse_h(300); pulse_l(100); wait_result(300, 100, 0);

    // Simultaneous hready/lready
    pulse_h(200);
    pulse_both(400, 200); wait_result(200, 200, 0);
    pulse_l(100); wait_result(400, 100, 0);

    // Overrun: second pair completes 5 edges after the first
    pulse_h(23437); pulse_l(7812);
    repeat (3) tick();
    pulse_h(5); pulse_l(5);
    chk("overrun_set", bus.overrun, 1);
    wait_result(23437, 7812, 5);
    quiet(20, "overrun_dropped");
    chk("overrun_held", bus.overrun, 1);
    pulse_clr();
    chk("overrun_clr", bus.overrun, 0);

    // Randomized pairs
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        rh = $urandom();
        rl = $urandom();
      end else begin
        rh = $urandom_range(0, 1000);
        rl = $urandom_range(0, 1000);
      end
      pulse_h(rh); pulse_l(rl); wait_result(rh, rl, 0);
    end

    // Reset in the middle of a division
    pulse_h(23437); pulse_l(7812); wait_result(23437, 7812, 0);
    pulse_h(1000); pulse_l(3000);
    repeat (5) tick();
    chk("pre_abort_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_duty", bus.duty, 0);
    chk("abort_period", bus.period, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.duty_valid, 0);
    tick();
    reset = 1'b1;
    quiet(20, "abort_no_valid");
    pulse_h(1); pulse_l(2); wait_result(1, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
